// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame geometry,
// oversample tick constants and the baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int unsigned UART_NB_DATA    = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;
   // Tick index at the middle of a bit (start-bit validation point)
   localparam int unsigned UART_MID_TICK   = 7;
   // Tick index at the end of a full bit period
   localparam int unsigned UART_LAST_TICK  = 15;

   // Clocks per oversample tick, integer floor, never below 1
   function automatic int unsigned uart_baud_div(input int unsigned clk_freq,
                                                 input int unsigned baud_rate,
                                                 input int unsigned oversample);
      int unsigned div;
      div = clk_freq / (baud_rate * oversample);
      return (div == 0) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line in, recovered byte and status strobes out.
// Optional macro UART_RX_PARITY_EN adds the o_parity_err strobe.
interface uart_rx_if #(
   parameter int unsigned NB_DATA = 8
);
   logic               i_rx;
   logic [NB_DATA-1:0] o_data;
   logic               o_rx_done;
   logic               o_frame_err;
   logic               o_busy;
`ifdef UART_RX_PARITY_EN
   logic               o_parity_err;
`endif

   // Receiver side
   modport master (
      input  i_rx,
      output o_data,
      output o_rx_done,
      output o_frame_err,
`ifdef UART_RX_PARITY_EN
      output o_parity_err,
`endif
      output o_busy
   );

   // Line driver / byte consumer side
   modport slave (
      output i_rx,
      input  o_data,
      input  o_rx_done,
      input  o_frame_err,
`ifdef UART_RX_PARITY_EN
      input  o_parity_err,
`endif
      input  o_busy
   );
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// Free-running oversample tick generator: one-clk o_tick every DIV clocks,
// DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE). Shared with the transmitter.
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD_RATE  = 19200,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic clk,
   input  logic i_rst,
   output logic o_tick
);
   localparam int unsigned DIV = uart_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..DIV-1 and wrap
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1 by default). Presents each good byte
// on o_data with a one-clk o_rx_done strobe; bad stop bit gives o_frame_err.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit before the
// stop bit and adds the o_parity_err strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned NB_DATA    = UART_NB_DATA,
   parameter int unsigned SB_TICK    = 16,
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD_RATE  = 19200,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic          clk,
   input  logic          i_rst,
   uart_rx_if.master     bus
);
   localparam int unsigned NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [NW-1:0] LAST_BIT  = NW'(NB_DATA - 1);
   localparam logic [3:0]    MID_TICK  = 4'(UART_MID_TICK);
   localparam logic [3:0]    LAST_TICK = 4'(UART_LAST_TICK);
   localparam logic [3:0]    STOP_TICK = 4'(SB_TICK - 1);

   logic               w_tick;
   logic               w_rx_s;
   logic               r_rx_meta;
   logic               r_rx_sync;
   uart_state_t        r_state;
   logic [3:0]         r_s_cnt;
   logic [NW-1:0]      r_n_cnt;
   logic [NB_DATA-1:0] r_shift;
   logic [NB_DATA-1:0] r_data;
   logic               r_done;
   logic               r_ferr;
   logic               r_busy;
`ifdef UART_RX_PARITY_EN
   logic               r_par;
   logic               r_perr;
`endif

   baud_tick_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk    (clk),
      .i_rst  (i_rst),
      .o_tick (w_tick)
   );

   // Two-flop synchronizer on the asynchronous line; resets to idle-high
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= bus.i_rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_rx_s = r_rx_sync;

   // Frame recovery FSM with registered data and status strobes
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_s_cnt <= '0;
         r_n_cnt <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
         r_perr  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= ST_START;
                  r_s_cnt <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (r_s_cnt == MID_TICK) begin
                     if (!w_rx_s) begin
                        r_state <= ST_DATA;
                        r_s_cnt <= '0;
                        r_n_cnt <= '0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_s_cnt == LAST_TICK) begin
                     r_shift <= {w_rx_s, r_shift[NB_DATA-1:1]};
                     r_s_cnt <= '0;
                     if (r_n_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                     end else begin
                        r_n_cnt <= r_n_cnt + 1'b1;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  if (r_s_cnt == LAST_TICK) begin
                     r_par   <= w_rx_s;
                     r_s_cnt <= '0;
                     r_state <= ST_STOP;
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  if (r_s_cnt == STOP_TICK) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     // Parity error and framing error are reported independently;
                     // a byte is only delivered when both are clean.
                     r_perr <= ^{r_shift, r_par};
                     if (!w_rx_s) begin
                        r_ferr <= 1'b1;
                     end else if (!(^{r_shift, r_par})) begin
                        r_data <= r_shift;
                        r_done <= 1'b1;
                     end
`else
                     if (w_rx_s) begin
                        r_data <= r_shift;
                        r_done <= 1'b1;
                     end else begin
                        r_ferr <= 1'b1;
                     end
`endif
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data      = r_data;
   assign bus.o_rx_done   = r_done;
   assign bus.o_frame_err = r_ferr;
   assign bus.o_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
   assign bus.o_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV = 4 (64 clocks per bit).
// Expected events are queued when frames are driven and checked by a
// negedge monitor as the receiver reports them.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned BAUD     = 15625;
   localparam int unsigned BIT_CLKS = 64;

   localparam logic [1:0] EV_BYTE = 2'd0;
   localparam logic [1:0] EV_FERR = 2'd1;
`ifdef UART_RX_PARITY_EN
   localparam logic [1:0] EV_PERR = 2'd2;
`endif

   typedef struct {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic i_rst;
   int   total;
   int   bad;
   exp_t exp_q[$];
   logic       prev_done;
   logic [7:0] prev_data;
`ifdef UART_RX_PARITY_EN
   logic par_flip;
`endif

   uart_rx_if #(.NB_DATA(8)) bus ();

   uart_rx #(
      .NB_DATA    (8),
      .SB_TICK    (16),
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (16)
   ) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t       e;
      logic [1:0] obs;
      logic       ev;
      if (i_rst) begin
         prev_done = 1'b0;
         prev_data = '0;
      end else begin
         ev  = bus.o_rx_done | bus.o_frame_err;
         obs = bus.o_rx_done ? EV_BYTE : EV_FERR;
`ifdef UART_RX_PARITY_EN
         ev = ev | bus.o_parity_err;
         if (bus.o_parity_err) obs = EV_PERR;
`endif
         if (ev) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_event kind=%0d data=%02h required=none", obs, bus.o_data);
            end else begin
               e = exp_q.pop_front();
               total++;
               if (obs !== e.kind) begin
                  bad++;
                  $display("FAIL event_kind got=%0d exp=%0d", obs, e.kind);
               end
               total++;
               if (bus.o_data !== e.data) begin
                  bad++;
                  $display("FAIL event_data got=%02h exp=%02h", bus.o_data, e.data);
               end
            end
         end
         if (bus.o_rx_done) begin
            total++;
            if (prev_done !== 1'b0) begin
               bad++;
               $display("FAIL rx_done_width got=multi-cycle exp=1");
            end
         end
         if (bus.o_data !== prev_data) begin
            total++;
            if (bus.o_rx_done !== 1'b1) begin
               bad++;
               $display("FAIL data_change_without_done got=%02h was=%02h", bus.o_data, prev_data);
            end
         end
         prev_done = bus.o_rx_done;
         prev_data = bus.o_data;
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      bus.i_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.i_rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      bus.i_rx = (^d) ^ par_flip;
      repeat (BIT_CLKS) @(negedge clk);
`endif
      if (stop_ok) begin
         bus.i_rx = 1'b1;
         repeat (BIT_CLKS) @(negedge clk);
      end else begin
         // Low across the stop sample point, back high before the mid-bit
         // check of the start the receiver re-enters afterwards.
         bus.i_rx = 1'b0;
         repeat (44) @(negedge clk);
         bus.i_rx = 1'b1;
         repeat (BIT_CLKS - 44) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      bus.i_rx = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if ({bus.o_data, bus.o_rx_done, bus.o_frame_err, bus.o_busy} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%03h exp=000",
                  {bus.o_data, bus.o_rx_done, bus.o_frame_err, bus.o_busy});
      end
      i_rst = 1'b0;
      repeat (100) @(negedge clk);
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_busy got=%b exp=0", bus.o_busy);
      end
   endtask

   task automatic test_single();
      exp_q.push_back('{EV_BYTE, 8'h5A});
      send_frame(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL single_pending got=%0d exp=0", exp_q.size());
      end
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL single_busy_after got=%b exp=0", bus.o_busy);
      end
      total++;
      if (bus.o_data !== 8'h5A) begin
         bad++;
         $display("FAIL single_data got=%02h exp=5a", bus.o_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      bytes[0] = 8'h01; bytes[1] = 8'hFF; bytes[2] = 8'h80;
      for (int i = 0; i < 3; i++) exp_q.push_back('{EV_BYTE, bytes[i]});
      for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_glitch();
      bus.i_rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.i_rx = 1'b1;
      repeat (200) @(negedge clk);
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_busy got=%b exp=0", bus.o_busy);
      end
      exp_q.push_back('{EV_BYTE, 8'h33});
      send_frame(8'h33, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL glitch_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_frame_err();
      exp_q.push_back('{EV_FERR, 8'h33});
      send_frame(8'h3C, 1'b0);
      repeat (200) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL ferr_pending got=%0d exp=0", exp_q.size());
      end
      total++;
      if (bus.o_data !== 8'h33) begin
         bad++;
         $display("FAIL ferr_data_hold got=%02h exp=33", bus.o_data);
      end
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL ferr_busy got=%b exp=0", bus.o_busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'hA5;
      bus.i_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.i_rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      total++;
      if (bus.o_busy !== 1'b1) begin
         bad++;
         $display("FAIL midframe_busy got=%b exp=1", bus.o_busy);
      end
      i_rst = 1'b1;
      bus.i_rx = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.o_data, bus.o_rx_done, bus.o_frame_err, bus.o_busy} !== 11'd0) begin
         bad++;
         $display("FAIL midreset_outputs got=%03h exp=000",
                  {bus.o_data, bus.o_rx_done, bus.o_frame_err, bus.o_busy});
      end
      i_rst = 1'b0;
      repeat (300) @(negedge clk);
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL postreset_busy got=%b exp=0", bus.o_busy);
      end
      exp_q.push_back('{EV_BYTE, 8'hA5});
      send_frame(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL postreset_pending got=%0d exp=0", exp_q.size());
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      exp_q.push_back('{EV_PERR, 8'hA5});
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL parity_err_pending got=%0d exp=0", exp_q.size());
      end
      exp_q.push_back('{EV_BYTE, 8'h07});
      send_frame(8'h07, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL parity_ok_pending got=%0d exp=0", exp_q.size());
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      prev_done = 1'b0;
      prev_data = '0;
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
